// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel dispatcher and its result combiner.
package pixel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam int SCREEN_WIDTH_DEF  = 640;
   localparam int SCREEN_HEIGHT_DEF = 480;
   localparam int NUM_ENGINES_DEF   = 6;
   localparam int ENGINE_BITS_DEF   = 3;

endpackage

// File: rtl/pixel_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo N.
module rr_arbiter
   import pixel_pkg::*;
#(
   parameter int N = NUM_ENGINES_DEF,
   parameter int B = ENGINE_BITS_DEF
) (
   input  logic [N-1:0] req,
   input  logic [B-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [B-1:0] idx,
   output logic         any_grant
);

   int cand;

   always_comb begin
      grant     = '0;
      idx       = '0;
      any_grant = 1'b0;
      cand      = 0;
      // k runs 1..N so the previously granted engine is searched last
      for (int k = 1; k <= N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!any_grant && req[cand]) begin
            grant[cand] = 1'b1;
            idx         = B'(cand);
            any_grant   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order pixel dispatcher: hands one pixel per cycle to idle engines,
// round-robin, with a cap on pixels outstanding downstream.
//
// state    | meaning
// IDLE     | waiting for start
// DISPATCH | handing out pixels in raster order
// DRAIN    | last pixel sent, waiting for outstanding to reach 0
// DONE     | one-cycle frame completion pulse
module pixel_dispatcher
   import pixel_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
   parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
   parameter int NUM_ENGINES   = NUM_ENGINES_DEF,
   parameter int ENGINE_BITS   = ENGINE_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NUM_ENGINES-1:0] engine_idle_i,
   input  logic                   retire_i,
   output logic [NUM_ENGINES-1:0] assign_o,
   output logic [DATA_WIDTH-1:0]  xpixel_o,
   output logic [DATA_WIDTH-1:0]  ypixel_o,
   output logic [ENGINE_BITS-1:0] grant_idx_o,
   output logic                   busy_o,
   output logic                   frame_done_o
);

   localparam logic [DATA_WIDTH-1:0]  X_LAST  = DATA_WIDTH'(SCREEN_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0]  Y_LAST  = DATA_WIDTH'(SCREEN_HEIGHT - 1);
   localparam logic [DATA_WIDTH-1:0]  ONE_D   = DATA_WIDTH'(1);
   localparam logic [ENGINE_BITS:0]   OUT_MAX = (ENGINE_BITS + 1)'(NUM_ENGINES);
   localparam logic [ENGINE_BITS:0]   ONE_O   = (ENGINE_BITS + 1)'(1);
   localparam logic [ENGINE_BITS-1:0] PTR_RST = ENGINE_BITS'(NUM_ENGINES - 1);

   state_t                 state, state_nxt;
   logic [DATA_WIDTH-1:0]  x, y;
   logic [ENGINE_BITS:0]   outstanding;
   logic [ENGINE_BITS-1:0] ptr;

   logic [NUM_ENGINES-1:0] eligible, grant;
   logic [ENGINE_BITS-1:0] grant_idx;
   logic                   any_grant, dispatch, last_pixel, retire_ok, abort_hit;

   // an engine strobed last cycle may not have lowered its idle flag yet
   assign eligible = engine_idle_i & ~assign_o;

   rr_arbiter #(.N(NUM_ENGINES), .B(ENGINE_BITS)) u_arb (
      .req       (eligible),
      .ptr       (ptr),
      .grant     (grant),
      .idx       (grant_idx),
      .any_grant (any_grant)
   );

   assign abort_hit  = abort && (state != ST_IDLE);
   assign dispatch   = (state == ST_DISPATCH) && !abort && (outstanding < OUT_MAX) && any_grant;
   assign last_pixel = (x == X_LAST) && (y == Y_LAST);
   assign retire_ok  = retire_i && (state != ST_IDLE) && (outstanding != '0);

   assign busy_o       = (state != ST_IDLE);
   assign frame_done_o = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (start && !abort) state_nxt = ST_DISPATCH;
         ST_DISPATCH: if (abort) state_nxt = ST_IDLE;
                      else if (dispatch && last_pixel) state_nxt = ST_DRAIN;
         ST_DRAIN:    if (abort) state_nxt = ST_IDLE;
                      else if (outstanding == '0) state_nxt = ST_DONE;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         x           <= '0;
         y           <= '0;
         outstanding <= '0;
         ptr         <= PTR_RST;
         assign_o    <= '0;
         xpixel_o    <= '0;
         ypixel_o    <= '0;
         grant_idx_o <= '0;
      end else begin
         state <= state_nxt;
         if (abort_hit) begin
            x           <= '0;
            y           <= '0;
            outstanding <= '0;
            assign_o    <= '0;
         end else begin
            assign_o <= dispatch ? grant : '0;
            if (dispatch) begin
               xpixel_o    <= x;
               ypixel_o    <= y;
               grant_idx_o <= grant_idx;
               ptr         <= grant_idx;
               if (x == X_LAST) begin
                  x <= '0;
                  y <= last_pixel ? '0 : y + ONE_D;
               end else begin
                  x <= x + ONE_D;
               end
            end
            case ({dispatch, retire_ok})
               2'b10:   outstanding <= outstanding + ONE_O;
               2'b01:   outstanding <= outstanding - ONE_O;
               default: outstanding <= outstanding;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher on a 4x2 screen with 3 engines;
// dispatched pixels are checked against a coordinate scoreboard and a grant model.
module tb_pixel_dispatcher;

   localparam int DW = 32;
   localparam int SW = 4;
   localparam int SH = 2;
   localparam int NE = 3;
   localparam int EB = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          retire_i = 1'b0;
   logic [NE-1:0] engine_idle_i = '1;
   logic [NE-1:0] assign_o;
   logic [DW-1:0] xpixel_o, ypixel_o;
   logic [EB-1:0] grant_idx_o;
   logic          busy_o, frame_done_o;

   pixel_dispatcher #(
      .DATA_WIDTH(DW), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
      .NUM_ENGINES(NE), .ENGINE_BITS(EB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .engine_idle_i (engine_idle_i),
      .retire_i      (retire_i),
      .assign_o      (assign_o),
      .xpixel_o      (xpixel_o),
      .ypixel_o      (ypixel_o),
      .grant_idx_o   (grant_idx_o),
      .busy_o        (busy_o),
      .frame_done_o  (frame_done_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cycle = 0;
   int n_disp = 0;
   int n_done = 0;
   int n_retired = 0;
   int retired_at_done = -1;
   int last_disp_cycle = -10;
   int exp_ptr = NE - 1;
   bit fixed_engine = 1'b0;
   bit auto_retire = 1'b0;
   int sb_x[$];
   int sb_y[$];
   int due[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      for (int yy = 0; yy < SH; yy++)
         for (int xx = 0; xx < SW; xx++) begin
            sb_x.push_back(xx);
            sb_y.push_back(yy);
         end
   endtask

   task automatic flush();
      sb_x.delete();
      sb_y.delete();
      due.delete();
      retire_i = 1'b0;
   endtask

   // one clock: sample outputs after the edge, score dispatches, then drive next inputs
   task automatic tick();
      int g;
      @(posedge clk);
      #1;
      cycle++;
      if (retire_i) n_retired++;
      if (frame_done_o) begin
         n_done++;
         retired_at_done = n_retired;
      end
      if (assign_o != '0) begin
         n_disp++;
         g = fixed_engine ? 2 : (exp_ptr + 1) % NE;
         exp_ptr = g;
         if (sb_x.size() == 0) begin
            check("unexpected_dispatch", assign_o, 0);
         end else begin
            check("xpixel", xpixel_o, sb_x.pop_front());
            check("ypixel", ypixel_o, sb_y.pop_front());
         end
         check("grant_idx", grant_idx_o, g);
         check("assign_onehot", assign_o, 64'(1) << g);
         if (fixed_engine) check("no_back_to_back", 64'(cycle - last_disp_cycle > 1), 1);
         last_disp_cycle = cycle;
         if (auto_retire) due.push_back(cycle + 2);
      end
      start = 1'b0;
      abort = 1'b0;
      retire_i = 1'b0;
      if (auto_retire && due.size() > 0 && due[0] <= cycle) begin
         void'(due.pop_front());
         retire_i = 1'b1;
      end
   endtask

   task automatic run_frame(input int max, input string tag);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (busy_o && k < max);
      check({tag, "_timeout"}, busy_o, 0);
   endtask

   initial begin
      // reset values
      #1;
      check("rst_assign", assign_o, 0);
      check("rst_x", xpixel_o, 0);
      check("rst_y", ypixel_o, 0);
      check("rst_grant", grant_idx_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", frame_done_o, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // full frame, retire 2 cycles after each dispatch
      push_frame();
      auto_retire = 1'b1;
      n_disp = 0; n_done = 0; n_retired = 0;
      start = 1'b1;
      tick();
      check("first_latency", assign_o, 0);
      check("busy_after_start", busy_o, 1);
      run_frame(60, "frame1");
      check("frame1_disp", n_disp, 8);
      check("frame1_done", n_done, 1);
      check("done_after_8_retires", retired_at_done, 8);
      check("frame1_sb_empty", sb_x.size(), 0);

      // no retires: outstanding cap stalls after 3, one retire frees one slot
      flush();
      auto_retire = 1'b0;
      push_frame();
      n_disp = 0; n_done = 0;
      start = 1'b1;
      tick();
      repeat (10) tick();
      check("stall_at_3", n_disp, 3);
      check("stall_assign", assign_o, 0);
      retire_i = 1'b1;
      tick();
      repeat (6) tick();
      check("one_more_disp", n_disp, 4);
      abort = 1'b1;
      tick();
      check("abort2_busy", busy_o, 0);
      check("abort2_no_done", n_done, 0);
      flush();

      // single idle engine: always engine 2, never back to back
      engine_idle_i = 3'b100;
      fixed_engine = 1'b1;
      auto_retire = 1'b1;
      push_frame();
      n_disp = 0; n_done = 0;
      start = 1'b1;
      tick();
      run_frame(80, "frame_e2");
      check("e2_disp", n_disp, 8);
      check("e2_done", n_done, 1);
      fixed_engine = 1'b0;
      engine_idle_i = '1;
      flush();

      // abort after the 5th dispatch, then restart from (0,0)
      push_frame();
      n_disp = 0; n_done = 0;
      start = 1'b1;
      tick();
      for (int k = 0; k < 30 && n_disp < 5; k++) tick();
      check("abort_reach5", n_disp, 5);
      abort = 1'b1;
      tick();
      check("abort_busy", busy_o, 0);
      check("abort_assign", assign_o, 0);
      flush();
      repeat (4) tick();
      check("abort_no_done", n_done, 0);
      check("abort_no_more_disp", n_disp, 5);
      push_frame();
      start = 1'b1;
      tick();
      run_frame(60, "restart");
      check("restart_disp", n_disp, 13);
      check("restart_done", n_done, 1);
      flush();

      // dispatch and retire in the same cycle at outstanding 2; retire in IDLE
      auto_retire = 1'b0;
      push_frame();
      n_disp = 0;
      start = 1'b1;
      tick();
      tick();
      tick();
      retire_i = 1'b1;
      tick();
      check("out_hold_2", dut.outstanding, 2);
      tick();
      check("out_after_4th", dut.outstanding, 3);
      check("disp_count_4", n_disp, 4);
      abort = 1'b1;
      tick();
      flush();
      retire_i = 1'b1;
      tick();
      check("idle_retire_out", dut.outstanding, 0);
      check("idle_retire_busy", busy_o, 0);

      // asynchronous reset mid-dispatch
      push_frame();
      start = 1'b1;
      tick();
      tick();
      tick();
      check("pre_reset_x", xpixel_o, 1);
      #2 reset = 1'b0;
      #1;
      check("async_assign", assign_o, 0);
      check("async_x", xpixel_o, 0);
      check("async_y", ypixel_o, 0);
      check("async_grant", grant_idx_o, 0);
      check("async_busy", busy_o, 0);
      check("async_done", frame_done_o, 0);
      flush();
      exp_ptr = NE - 1;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) tick();
      check("post_reset_busy", busy_o, 0);
      check("post_reset_assign", assign_o, 0);
      n_disp = 0;
      push_frame();
      start = 1'b1;
      tick();
      tick();
      check("post_reset_first", n_disp, 1);
      abort = 1'b1;
      tick();
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
